// File: rtl/crc_pkg.sv
// Shared definitions for the CRC check path: frame sequencer states,
// CRC-16/CCITT-FALSE polynomial and the default register seed.
package crc_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StData,
    StHashHi,
    StHashLo,
    StCheck
  } crc_frm_state_t;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

endpackage

// File: rtl/crc16_byte.sv
// Combinational CRC-16 byte step (poly 0x1021, MSB-first, no reflection).
// Ports:
//   crc_i  - current CRC register value
//   data_i - byte to fold in, bit 7 first
//   crc_o  - CRC after folding in data_i
module crc16_byte
  import crc_pkg::*;
(
  input  logic [15:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [15:0] crc_o
);

  logic [15:0] crc_tmp;

  always_comb begin
    crc_tmp = crc_i;
    for (int i = 7; i >= 0; i--) begin
      if (crc_tmp[15] ^ data_i[i]) begin
        crc_tmp = {crc_tmp[14:0], 1'b0} ^ CRC16_POLY;
      end else begin
        crc_tmp = {crc_tmp[14:0], 1'b0};
      end
    end
    crc_o = crc_tmp;
  end

endmodule

// File: rtl/crc_frame_ctrl.sv
// Frame sequencer for the CRC check path. Takes a start command with a
// payload length, then payload bytes and a 16-bit trailing hash over a
// valid/ready byte stream, and presents the computed CRC and received hash
// with a one-cycle crc_rdy strobe. A stall watchdog aborts stuck frames.
// Ports:
//   clk50m, rst_n        - clock, asynchronous active-low reset
//   frm_start, frm_len   - start command and payload length (IDLE only)
//   din, din_valid       - stream byte and its valid
//   din_ready            - byte accepted this cycle when din_valid is high
//   busy                 - frame in progress
//   crc_calc, crc_hash   - computed CRC and received hash
//   crc_rdy              - one-cycle result strobe
//   err_tmo              - one-cycle watchdog abort strobe
module crc_frame_ctrl
  import crc_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 1000,
  parameter logic [15:0] CRC_INIT    = CRC16_INIT
) (
  input  logic        clk50m,
  input  logic        rst_n,
  input  logic        frm_start,
  input  logic [7:0]  frm_len,
  input  logic [7:0]  din,
  input  logic        din_valid,
  output logic        din_ready,
  output logic        busy,
  output logic [15:0] crc_calc,
  output logic [15:0] crc_hash,
  output logic        crc_rdy,
  output logic        err_tmo
);

  localparam int unsigned WdogW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [WdogW-1:0] WdogLast = WdogW'(TIMEOUT_CYC - 1);
  localparam logic [WdogW-1:0] WdogOne  = WdogW'(1);

  crc_frm_state_t   state_q, state_d;
  logic [7:0]       len_q, len_d;
  logic [WdogW-1:0] wdog_q, wdog_d;
  logic [15:0]      crc_q, crc_d;
  logic [15:0]      hash_q, hash_d;
  logic [15:0]      crc_next;
  logic             accept;

  crc16_byte u_crc16_byte (
    .crc_i  (crc_q),
    .data_i (din),
    .crc_o  (crc_next)
  );

  assign accept   = din_valid && din_ready;
  assign crc_calc = crc_q;
  assign crc_hash = hash_q;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    wdog_d    = wdog_q;
    crc_d     = crc_q;
    hash_d    = hash_q;
    din_ready = 1'b0;
    busy      = 1'b1;
    crc_rdy   = 1'b0;
    err_tmo   = 1'b0;

    unique case (state_q)
      StIdle: begin
        busy   = 1'b0;
        wdog_d = '0;
        if (frm_start) begin
          len_d   = frm_len;
          crc_d   = CRC_INIT;
          hash_d  = '0;
          state_d = (frm_len != 8'd0) ? StData : StHashHi;
        end
      end
      StData: begin
        din_ready = 1'b1;
        if (accept) begin
          crc_d = crc_next;
          len_d = len_q - 8'd1;
          if (len_q == 8'd1) begin
            state_d = StHashHi;
          end
        end
      end
      StHashHi: begin
        din_ready = 1'b1;
        if (accept) begin
          hash_d[15:8] = din;
          state_d      = StHashLo;
        end
      end
      StHashLo: begin
        din_ready = 1'b1;
        if (accept) begin
          hash_d[7:0] = din;
          state_d     = StCheck;
        end
      end
      StCheck: begin
        crc_rdy = 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Watchdog runs only while bytes are expected; an acceptance in the
    // limit cycle wins over the abort.
    if (din_ready) begin
      if (accept) begin
        wdog_d = '0;
      end else if (wdog_q == WdogLast) begin
        err_tmo = 1'b1;
        wdog_d  = '0;
        len_d   = '0;
        state_d = StIdle;
      end else begin
        wdog_d = wdog_q + WdogOne;
      end
    end
  end

  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      len_q   <= '0;
      wdog_q  <= '0;
      crc_q   <= CRC_INIT;
      hash_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      wdog_q  <= wdog_d;
      crc_q   <= crc_d;
      hash_q  <= hash_d;
    end
  end

endmodule

// File: tb/tb_crc_frame_ctrl.sv
// Self-checking bench for crc_frame_ctrl with a small watchdog limit.
module tb_crc_frame_ctrl;

  typedef logic [7:0] byte_q_t[$];

  logic        clk50m = 1'b0;
  logic        rst_n;
  logic        frm_start;
  logic [7:0]  frm_len;
  logic [7:0]  din;
  logic        din_valid;
  logic        din_ready;
  logic        busy;
  logic [15:0] crc_calc;
  logic [15:0] crc_hash;
  logic        crc_rdy;
  logic        err_tmo;

  always #10 clk50m = ~clk50m;

  crc_frame_ctrl #(
    .TIMEOUT_CYC (8),
    .CRC_INIT    (16'hFFFF)
  ) dut (
    .clk50m    (clk50m),
    .rst_n     (rst_n),
    .frm_start (frm_start),
    .frm_len   (frm_len),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .busy      (busy),
    .crc_calc  (crc_calc),
    .crc_hash  (crc_hash),
    .crc_rdy   (crc_rdy),
    .err_tmo   (err_tmo)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];
  byte_q_t     acc_q;

  int cyc = 0;
  int rdy_cnt = 0;
  int tmo_cnt = 0;
  int rdy_viol = 0;
  int first_acc_cyc, last_acc_cyc, rdy_cyc, tmo_cyc, start_cyc;
  bit acc_s, rdy_s, post_start_ok, stuck;

  // Bitwise reference CRC-16/CCITT-FALSE.
  function automatic logic [15:0] crc_model(input byte_q_t d);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    foreach (d[k]) begin
      for (int b = 7; b >= 0; b--) begin
        fb = c[15] ^ d[k][b];
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h1021;
      end
    end
    return c;
  endfunction

  function automatic byte_q_t ascii9();
    byte_q_t q;
    for (int k = 0; k < 9; k++) q.push_back(8'(8'h31 + k));
    return q;
  endfunction

  // Observe the current cycle with inputs already applied, then advance.
  task automatic cycle();
    #1;
    acc_s = din_valid && din_ready;
    rdy_s = crc_rdy;
    if (acc_s) begin
      acc_q.push_back(din);
      if (first_acc_cyc < 0) first_acc_cyc = cyc;
      last_acc_cyc = cyc;
    end
    if (crc_rdy) begin
      rdy_cnt++;
      rdy_cyc = cyc;
      obs_q.push_back({crc_calc, crc_hash});
    end
    if (err_tmo) begin
      tmo_cnt++;
      tmo_cyc = cyc;
    end
    if (din_ready && (!busy || crc_rdy)) rdy_viol++;
    cyc++;
    @(posedge clk50m);
    #1;
  endtask

  // Drive one frame; stop_after >= 0 sends only that many payload bytes.
  task automatic run_frame(input byte_q_t pl, input logic [15:0] hash, input int gap_max,
                           input bit hold_start, input int stop_after);
    byte_q_t stream;
    int      n;
    int      tries;
    n = (stop_after < 0) ? pl.size() : stop_after;
    for (int k = 0; k < n; k++) stream.push_back(pl[k]);
    if (stop_after < 0) begin
      stream.push_back(hash[15:8]);
      stream.push_back(hash[7:0]);
    end
    acc_q.delete();
    first_acc_cyc = -1;
    stuck         = 1'b0;
    rdy_s         = 1'b0;
    start_cyc     = cyc;
    frm_start     = 1'b1;
    frm_len       = 8'(pl.size());
    din_valid     = 1'b0;
    cycle();
    post_start_ok = busy && din_ready;
    frm_start     = hold_start;
    frm_len       = 8'd3;
    foreach (stream[k]) begin
      if (k >= pl.size()) frm_start = 1'b0;
      if (gap_max > 0) begin
        repeat ($urandom_range(0, gap_max)) begin
          din_valid = 1'b0;
          din       = 8'($urandom);
          cycle();
        end
      end
      din_valid = 1'b1;
      din       = stream[k];
      tries     = 0;
      do begin
        cycle();
        tries++;
      end while (!acc_s && tries < 16);
      if (!acc_s) begin
        stuck = 1'b1;
        break;
      end
    end
    din_valid = 1'b0;
    frm_start = 1'b0;
    if (stop_after < 0 && !stuck) begin
      tries = 0;
      do begin
        cycle();
        tries++;
      end while (!rdy_s && tries < 4);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; frm_start = 1'b0; frm_len = 8'd0; din = 8'h00; din_valid = 1'b0;
    #25;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (din_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", din_ready); end
    checks++; if (crc_rdy !== 1'b0 || err_tmo !== 1'b0) begin
      errors++; $display("FAIL reset_strobes got %b%b want 00", crc_rdy, err_tmo); end
    checks++; if (crc_calc !== 16'hFFFF) begin errors++; $display("FAIL reset_crc got %h want ffff", crc_calc); end
    checks++; if (crc_hash !== 16'h0000) begin errors++; $display("FAIL reset_hash got %h want 0000", crc_hash); end
    #3 rst_n = 1'b1;
    @(posedge clk50m);
    #1;
    // Bytes offered in IDLE must not be consumed.
    acc_q.delete();
    din_valid = 1'b1; din = 8'hA5;
    repeat (3) cycle();
    din_valid = 1'b0;
    checks++; if (acc_q.size() != 0) begin
      errors++; $display("FAIL idle_consume got %0d bytes want 0", acc_q.size()); end
  endtask

  task automatic test_good_frame();
    logic [31:0] o, e;
    byte_q_t pl;
    pl = ascii9();
    exp_q.push_back({crc_model(pl), 16'h29B1});
    run_frame(pl, 16'h29B1, 0, 1'b0, -1);
    checks++; if (!post_start_ok) begin errors++; $display("FAIL start_latency got 0 want busy&ready"); end
    checks++; if (obs_q.size() != 1) begin
      errors++; $display("FAIL good_rdy_count got %0d want 1", obs_q.size());
    end else begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL good_result got %h want %h", o, e); end
      checks++; if (o[31:16] !== 16'h29B1) begin
        errors++; $display("FAIL good_crc_const got %h want 29b1", o[31:16]); end
    end
    checks++; if (rdy_cyc - last_acc_cyc != 1) begin
      errors++; $display("FAIL good_rdy_lat got %0d want 1", rdy_cyc - last_acc_cyc); end
    checks++; if (last_acc_cyc - first_acc_cyc != 10 || acc_q.size() != 11) begin
      errors++; $display("FAIL good_accept_span got %0d/%0d want 10/11",
                         last_acc_cyc - first_acc_cyc, acc_q.size()); end
    checks++; if (first_acc_cyc - start_cyc != 1) begin
      errors++; $display("FAIL good_first_acc got %0d want 1", first_acc_cyc - start_cyc); end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_bad_hash();
    logic [31:0] o, e;
    byte_q_t pl;
    pl = ascii9();
    exp_q.push_back({crc_model(pl), 16'h1234});
    run_frame(pl, 16'h1234, 0, 1'b0, -1);
    checks++; if (obs_q.size() != 1) begin
      errors++; $display("FAIL bad_rdy_count got %0d want 1", obs_q.size());
    end else begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL bad_result got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_zero_len();
    logic [31:0] o, e;
    byte_q_t pl;
    exp_q.push_back({16'hFFFF, 16'hFFFF});
    run_frame(pl, 16'hFFFF, 0, 1'b0, -1);
    checks++; if (acc_q.size() != 2) begin
      errors++; $display("FAIL zero_accepts got %0d want 2", acc_q.size()); end
    checks++; if (obs_q.size() != 1) begin
      errors++; $display("FAIL zero_rdy_count got %0d want 1", obs_q.size());
    end else begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL zero_result got %h want %h", o, e); end
    end
    checks++; if (rdy_cyc - last_acc_cyc != 1) begin
      errors++; $display("FAIL zero_rdy_lat got %0d want 1", rdy_cyc - last_acc_cyc); end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_random_valid();
    logic [31:0] o, e;
    byte_q_t pl, want;
    int      bad;
    pl = ascii9();
    want = pl;
    want.push_back(8'h29);
    want.push_back(8'hB1);
    for (int r = 0; r < 3; r++) begin
      exp_q.push_back({16'h29B1, 16'h29B1});
      run_frame(pl, 16'h29B1, 4, 1'b0, -1);
      bad = 0;
      if (acc_q.size() != want.size()) bad++;
      else foreach (want[k]) if (acc_q[k] !== want[k]) bad++;
      checks++; if (bad != 0) begin
        errors++; $display("FAIL rand_stream got %0d bytes (%0d bad) want %0d", acc_q.size(), bad,
                           want.size()); end
      checks++; if (obs_q.size() != 1) begin
        errors++; $display("FAIL rand_rdy_count got %0d want 1", obs_q.size());
      end else begin
        o = obs_q.pop_front(); e = exp_q.pop_front();
        checks++; if (o !== e) begin errors++; $display("FAIL rand_result got %h want %h", o, e); end
      end
      exp_q.delete(); obs_q.delete();
    end
  endtask

  task automatic test_timeout();
    int rdy0, tmo0, tries;
    logic [31:0] o;
    byte_q_t pl;
    pl = ascii9();
    rdy0 = rdy_cnt; tmo0 = tmo_cnt;
    run_frame(pl, 16'h0000, 0, 1'b0, 3);
    tries = 0;
    while (tmo_cnt == tmo0 && tries < 20) begin
      cycle();
      tries++;
    end
    checks++; if (tmo_cnt != tmo0 + 1) begin
      errors++; $display("FAIL tmo_pulse got %0d want 1", tmo_cnt - tmo0); end
    checks++; if (tmo_cyc - last_acc_cyc != 8) begin
      errors++; $display("FAIL tmo_delay got %0d want 8", tmo_cyc - last_acc_cyc); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tmo_busy got %b want 0", busy); end
    repeat (3) cycle();
    checks++; if (rdy_cnt != rdy0 || tmo_cnt != tmo0 + 1) begin
      errors++; $display("FAIL tmo_strobes got rdy %0d tmo %0d want 0/1", rdy_cnt - rdy0,
                         tmo_cnt - tmo0); end
    obs_q.delete();
    run_frame(pl, 16'h29B1, 0, 1'b0, -1);
    o = (obs_q.size() == 1) ? obs_q.pop_front() : 32'hx;
    checks++; if (o !== {16'h29B1, 16'h29B1}) begin
      errors++; $display("FAIL tmo_recover got %h want 29b129b1", o); end
    obs_q.delete();
  endtask

  task automatic test_reset_mid();
    int rdy0, tmo0;
    byte_q_t pl;
    pl = ascii9();
    run_frame(pl, 16'h0000, 0, 1'b0, 5);
    rdy0 = rdy_cnt; tmo0 = tmo_cnt;
    rst_n = 1'b0;
    #1;
    checks++; if ({busy, din_ready, crc_rdy, err_tmo} !== 4'b0000) begin
      errors++; $display("FAIL midrst_ctrl got %b want 0000", {busy, din_ready, crc_rdy, err_tmo});
    end
    checks++; if ({crc_calc, crc_hash} !== {16'hFFFF, 16'h0000}) begin
      errors++; $display("FAIL midrst_data got %h want ffff0000", {crc_calc, crc_hash}); end
    @(posedge clk50m);
    #1;
    rst_n = 1'b1;
    repeat (12) cycle();
    checks++; if (rdy_cnt != rdy0 || tmo_cnt != tmo0 || busy !== 1'b0) begin
      errors++; $display("FAIL midrst_after got rdy %0d tmo %0d busy %b want 0 0 0",
                         rdy_cnt - rdy0, tmo_cnt - tmo0, busy); end
  endtask

  task automatic test_start_busy();
    logic [31:0] o, e;
    byte_q_t pl;
    pl = ascii9();
    exp_q.push_back({crc_model(pl), 16'hBEEF});
    run_frame(pl, 16'hBEEF, 1, 1'b1, -1);
    checks++; if (acc_q.size() != 11) begin
      errors++; $display("FAIL busy_start_accepts got %0d want 11", acc_q.size()); end
    checks++; if (obs_q.size() != 1) begin
      errors++; $display("FAIL busy_start_rdy got %0d want 1", obs_q.size());
    end else begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL busy_start_result got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_back_to_back();
    int rdy_first;
    logic [31:0] o;
    byte_q_t pl;
    pl = ascii9();
    run_frame(pl, 16'h29B1, 0, 1'b0, -1);
    rdy_first = rdy_cyc;
    obs_q.delete();
    run_frame(pl, 16'h5555, 0, 1'b0, -1);
    checks++; if (start_cyc - rdy_first != 1 || !post_start_ok) begin
      errors++; $display("FAIL b2b_start got gap %0d ok %b want 1 1", start_cyc - rdy_first,
                         post_start_ok); end
    o = (obs_q.size() == 1) ? obs_q.pop_front() : 32'hx;
    checks++; if (o !== {16'h29B1, 16'h5555}) begin
      errors++; $display("FAIL b2b_result got %h want 29b15555", o); end
    obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_hash();
    test_zero_len();
    test_random_valid();
    test_timeout();
    test_reset_mid();
    test_start_busy();
    test_back_to_back();
    checks++; if (rdy_viol != 0) begin
      errors++; $display("FAIL ready_idle_check got %0d violations want 0", rdy_viol); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got no finish want finish before 2ms");
    $fatal(1, "bench time limit");
  end

endmodule
